// File: rtl/rv32_mc_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing with sticky trap.
// Optional retired-instruction counter enabled by defining RV32_CTRL_RETIRE_CNT_EN.
//
// state  | meaning
// FETCH  | request instruction, latch IR and PC+4 on ready
// DECODE | classify instruction (illegal -> TRAP, NOP -> FETCH)
// EXEC   | ALU operation, branches and jumps resolve here
// MEM    | data access for load/store
// WB     | register file write (ALU result or load data)
// TRAP   | terminal until reset
module rv32_mc_control #(
    parameter int unsigned MAX_WAIT = 0,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  dec_type_i,
    input  logic [6:0]  dec_opcode_i,
    input  logic        branch_taken_i,
    output logic        imem_req_o,
    input  logic        imem_ready_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ready_i,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic [1:0]  alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o
`ifdef RV32_CTRL_RETIRE_CNT_EN
    ,
    output logic [63:0] retired_o
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [2:0] T_ILL = 3'd0, T_R = 3'd1, T_S = 3'd4, T_B = 3'd5, T_J = 3'd6, T_NOP = 3'd7;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_JALR = 7'b1100111,
                           OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_inc;
    logic                trap_q;
    logic [1:0]          cause_q, cause_d;
    logic                is_load, is_store, is_jalr, waiting, wait_hit;

    assign is_load  = (dec_opcode_i == OP_LOAD);
    assign is_store = (dec_type_i == T_S);
    assign is_jalr  = (dec_opcode_i == OP_JALR);
    assign wait_inc = wait_q + WAIT_W'(1);
    assign waiting  = (state_q == S_FETCH && !imem_ready_i) || (state_q == S_MEM && !dmem_ready_i);
    // Limit is hit when this unanswered cycle would bring the count up to MAX_WAIT.
    assign wait_hit = (MAX_WAIT != 0) && (wait_inc == WAIT_W'(MAX_WAIT));

    always_comb begin
        state_d     = state_q;
        cause_d     = 2'd0;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 2'd0;
        rf_we_o     = 1'b0;
        wb_sel_o    = 2'd0;
        alu_b_sel_o = (dec_type_i != T_R) && (dec_type_i != T_B);
        alu_a_sel_o = (dec_opcode_i == OP_LUI)   ? 2'd1 :
                      (dec_opcode_i == OP_AUIPC) ? 2'd2 : 2'd0;
        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (dec_type_i == T_ILL) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else if (dec_type_i == T_NOP) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // PC already holds PC+4 here, so the link value is the current PC.
                if (is_jalr) begin
                    rf_we_o  = 1'b1;
                    wb_sel_o = 2'd2;
                    pc_we_o  = 1'b1;
                    pc_sel_o = 2'd2;
                    state_d  = S_FETCH;
                end else if (dec_type_i == T_J) begin
                    rf_we_o  = 1'b1;
                    wb_sel_o = 2'd2;
                    pc_we_o  = 1'b1;
                    pc_sel_o = 2'd1;
                    state_d  = S_FETCH;
                end else if (dec_type_i == T_B) begin
                    pc_we_o  = branch_taken_i;
                    pc_sel_o = 2'd1;
                    state_d  = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d  = S_MEM;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_store;
                if (dmem_ready_i) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (wait_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_WB: begin
                rf_we_o  = 1'b1;
                wb_sel_o = is_load ? 2'd1 : 2'd0;
                state_d  = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase
        if (rst_i) begin
            imem_req_o = 1'b0;
            dmem_req_o = 1'b0;
            ir_we_o    = 1'b0;
            pc_we_o    = 1'b0;
            rf_we_o    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP && state_q != S_TRAP) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
            if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
                wait_q <= '0;
            else if (waiting)
                wait_q <= wait_inc;
        end
    end

`ifdef RV32_CTRL_RETIRE_CNT_EN
    logic [63:0] retired_q;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            retired_q <= '0;
        else if (state_d == S_FETCH &&
                 (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB))
            retired_q <= retired_q + 64'd1;
    end
    assign retired_o = retired_q;
`endif

    assign state_o      = state_q;
    assign trap_o       = trap_q;
    assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_rv32_mc_control.sv
// Directed vector bench for rv32_mc_control (instance built with MAX_WAIT=4).
module tb_rv32_mc_control;

    localparam logic [2:0] T_ILL = 3'd0, T_R = 3'd1, T_I = 3'd2, T_U = 3'd3,
                           T_S = 3'd4, T_B = 3'd5, T_J = 3'd6, T_NOP = 3'd7;
    localparam logic [6:0] OP_R = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JALR = 7'b1100111,
                           OP_JAL = 7'b1101111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    // output bit layout: imem,dmem,we,ir,pc,pcs[2],a[2],b,rf,wb[2]
    localparam logic [12:0] M_STB = 13'b1101100000100, M_WE = 13'h0400, M_PCS = 13'h00C0,
                            M_A = 13'h0030, M_B = 13'h0008, M_WB = 13'h0003;

    logic clk = 1'b0, rst = 1'b1;
    logic [2:0] dec_type = 3'd0;
    logic [6:0] dec_opcode = 7'd0;
    logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_b_sel, rf_we, trap;
    logic [1:0] pc_sel, alu_a_sel, wb_sel, trap_cause;
    logic [2:0] state;
`ifdef RV32_CTRL_RETIRE_CNT_EN
    logic [63:0] retired;
`endif

    int n_checks = 0, n_fail = 0;

    rv32_mc_control #(.MAX_WAIT(4), .WAIT_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .dec_type_i(dec_type), .dec_opcode_i(dec_opcode),
        .branch_taken_i(branch_taken), .imem_req_o(imem_req), .imem_ready_i(imem_ready),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ready_i(dmem_ready),
        .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel), .alu_a_sel_o(alu_a_sel),
        .alu_b_sel_o(alu_b_sel), .rf_we_o(rf_we), .wb_sel_o(wb_sel), .state_o(state),
        .trap_o(trap), .trap_cause_o(trap_cause)
`ifdef RV32_CTRL_RETIRE_CNT_EN
        , .retired_o(retired)
`endif
    );

    always #5 clk = ~clk;

    logic [12:0] act;
    logic [4:0]  strobes;
    assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, rf_we, wb_sel};
    assign strobes = {imem_req, dmem_req, ir_we, pc_we, rf_we};

    typedef struct {
        logic [2:0]  ty;
        logic [6:0]  op;
        logic        bt;
        logic        ir;
        logic        dr;
        logic [2:0]  st;
        logic [12:0] exp;
        logic [12:0] msk;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [12:0] ob(input logic imem, dmem, we, ir, pc, input logic [1:0] pcs, as,
                                       input logic bs, rf, input logic [1:0] wb);
        return {imem, dmem, we, ir, pc, pcs, as, bs, rf, wb};
    endfunction

    task automatic add(input logic [2:0] ty, input logic [6:0] op, input logic bt, ir, dr,
                       input logic [2:0] st, input logic [12:0] exp, msk);
        vec_t v;
        v.ty = ty; v.op = op; v.bt = bt; v.ir = ir; v.dr = dr; v.st = st; v.exp = exp; v.msk = msk;
        vecs.push_back(v);
    endtask

    task automatic add_fd(input logic [2:0] ty, input logic [6:0] op);
        add(ty, op, 1'b0, 1'b1, 1'b0, 3'd0, ob(1,0,0,1,1,2'd0,2'd0,0,0,2'd0), M_STB | M_PCS);
        add(ty, op, 1'b0, 1'b0, 1'b0, 3'd1, 13'd0, M_STB);
    endtask

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [2:0] ty, input logic [6:0] op, input logic ir, dr);
        dec_type = ty; dec_opcode = op; imem_ready = ir; dmem_ready = dr; branch_taken = 1'b0;
    endtask

    initial begin
        // ADD x3,x1,x2
        add_fd(T_R, OP_R);
        add(T_R, OP_R, 0, 0, 0, 3'd2, ob(0,0,0,0,0,2'd0,2'd0,0,0,2'd0), M_STB | M_B);
        add(T_R, OP_R, 0, 0, 0, 3'd4, ob(0,0,0,0,0,2'd0,2'd0,0,1,2'd0), M_STB | M_B | M_WB);
        // LW x5,4(x1), dmem_ready after 3 wait cycles
        add_fd(T_I, OP_LOAD);
        add(T_I, OP_LOAD, 0, 0, 0, 3'd2, ob(0,0,0,0,0,2'd0,2'd0,1,0,2'd0), M_STB | M_B);
        for (int k = 0; k < 4; k++)
            add(T_I, OP_LOAD, 0, 0, (k == 3), 3'd3, ob(0,1,0,0,0,2'd0,2'd0,0,0,2'd0), M_STB | M_WE);
        add(T_I, OP_LOAD, 0, 0, 0, 3'd4, ob(0,0,0,0,0,2'd0,2'd0,0,1,2'd1), M_STB | M_WB);
        // BEQ taken / not taken
        add_fd(T_B, OP_BR);
        add(T_B, OP_BR, 1, 0, 0, 3'd2, ob(0,0,0,0,1,2'd1,2'd0,0,0,2'd0), M_STB | M_PCS | M_B);
        add_fd(T_B, OP_BR);
        add(T_B, OP_BR, 0, 0, 0, 3'd2, ob(0,0,0,0,0,2'd0,2'd0,0,0,2'd0), M_STB | M_B);
        // JALR x1,0(x2)
        add_fd(T_I, OP_JALR);
        add(T_I, OP_JALR, 0, 0, 0, 3'd2, ob(0,0,0,0,1,2'd2,2'd0,1,1,2'd2), M_STB | M_PCS | M_A | M_B | M_WB);
        // JAL
        add_fd(T_J, OP_JAL);
        add(T_J, OP_JAL, 0, 0, 0, 3'd2, ob(0,0,0,0,1,2'd1,2'd0,0,1,2'd2), M_STB | M_PCS | M_WB);
        // LUI, AUIPC
        add_fd(T_U, OP_LUI);
        add(T_U, OP_LUI, 0, 0, 0, 3'd2, ob(0,0,0,0,0,2'd0,2'd1,1,0,2'd0), M_STB | M_A | M_B);
        add(T_U, OP_LUI, 0, 0, 0, 3'd4, ob(0,0,0,0,0,2'd0,2'd1,1,1,2'd0), M_STB | M_A | M_B | M_WB);
        add_fd(T_U, OP_AUIPC);
        add(T_U, OP_AUIPC, 0, 0, 0, 3'd2, ob(0,0,0,0,0,2'd0,2'd2,1,0,2'd0), M_STB | M_A | M_B);
        add(T_U, OP_AUIPC, 0, 0, 0, 3'd4, ob(0,0,0,0,0,2'd0,2'd2,1,1,2'd0), M_STB | M_A | M_B | M_WB);
        // SW, zero-wait
        add_fd(T_S, OP_STORE);
        add(T_S, OP_STORE, 0, 0, 0, 3'd2, ob(0,0,0,0,0,2'd0,2'd0,1,0,2'd0), M_STB | M_B);
        add(T_S, OP_STORE, 0, 0, 1, 3'd3, ob(0,1,1,0,0,2'd0,2'd0,0,0,2'd0), M_STB | M_WE);
        // NOP
        add_fd(T_NOP, OP_IMM);
        // ADDI with imem_ready on the 4th FETCH cycle (limit cycle, ready wins)
        for (int k = 0; k < 3; k++)
            add(T_I, OP_IMM, 0, 0, 0, 3'd0, ob(1,0,0,0,0,2'd0,2'd0,0,0,2'd0), M_STB);
        add_fd(T_I, OP_IMM);
        add(T_I, OP_IMM, 0, 0, 0, 3'd2, ob(0,0,0,0,0,2'd0,2'd0,1,0,2'd0), M_STB | M_B);
        add(T_I, OP_IMM, 0, 0, 0, 3'd4, ob(0,0,0,0,0,2'd0,2'd0,1,1,2'd0), M_STB | M_B | M_WB);
        add_fd(T_NOP, OP_IMM);

        // reset: strobes held low even with imem_ready high
        drive(T_R, OP_R, 1'b1, 1'b1);
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("reset strobes", 64'(strobes), 64'd0);
        chk("reset state", 64'(state), 64'd0);
        chk("reset trap", 64'({trap, trap_cause}), 64'd0);
        step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            dec_type = vecs[i].ty; dec_opcode = vecs[i].op; branch_taken = vecs[i].bt;
            imem_ready = vecs[i].ir; dmem_ready = vecs[i].dr;
            @(negedge clk);
            chk($sformatf("vec%0d state", i), 64'(state), 64'(vecs[i].st));
            chk($sformatf("vec%0d outs", i), 64'(act & vecs[i].msk), 64'(vecs[i].exp & vecs[i].msk));
            step();
        end
        chk("after table trap", 64'({trap, trap_cause}), 64'd0);

        // illegal instruction -> TRAP, terminal, cleared by reset
        do_reset();
        drive(T_ILL, 7'd0, 1'b1, 1'b1);
        repeat (2) step();
        chk("ill state", 64'(state), 64'd5);
        chk("ill trap", 64'({trap, trap_cause}), 64'({1'b1, 2'd1}));
        drive(T_R, OP_R, 1'b1, 1'b1);
        branch_taken = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("trap hold %0d", k), 64'({state, strobes}), 64'({3'd5, 5'd0}));
            step();
        end
        chk("trap sticky", 64'({trap, trap_cause}), 64'({1'b1, 2'd1}));
`ifdef RV32_CTRL_RETIRE_CNT_EN
        chk("retired after trap", retired, 64'd0);
`endif
        do_reset();
        chk("post-trap reset", 64'({state, trap, trap_cause}), 64'd0);

        // fetch timeout after 4 unanswered cycles
        drive(T_R, OP_R, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("fetch wait %0d", k), 64'({state, imem_req}), 64'({3'd0, 1'b1}));
            step();
        end
        chk("fetch timeout", 64'({state, trap, trap_cause}), 64'({3'd5, 1'b1, 2'd2}));

        // reset mid data handshake, then data timeout
        do_reset();
        drive(T_S, OP_STORE, 1'b1, 1'b0);
        repeat (3) step();
        imem_ready = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid-mem strobes", 64'(strobes), 64'd0);
        step();
        rst = 1'b0;
        chk("rst mid-mem state", 64'(state), 64'd0);
        imem_ready = 1'b1;
        repeat (3) step();
        imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mem wait %0d", k), 64'({state, dmem_req, dmem_we}), 64'({3'd3, 1'b1, 1'b1}));
            step();
        end
        chk("mem timeout", 64'({state, trap, trap_cause}), 64'({3'd5, 1'b1, 2'd2}));

`ifdef RV32_CTRL_RETIRE_CNT_EN
        do_reset();
        drive(T_R, OP_R, 1'b1, 1'b1);
        repeat (4) step();
        drive(T_S, OP_STORE, 1'b1, 1'b1);
        repeat (4) step();
        drive(T_NOP, OP_IMM, 1'b1, 1'b1);
        repeat (2) step();
        chk("retired count", retired, 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
